// File: rtl/id_ram_pkg.sv
// Shared sizes, arbitration modes and FSM state type for the sprite-ID RAM access controller.
package id_ram_pkg;
  localparam int ID_DATA_W = 24;
  localparam int ID_ADDR_W = 5;
  localparam int ID_DEPTH  = 32;

  localparam int PRIO_RR = 0;
  localparam int PRIO_RD = 1;

  typedef enum logic {S_CLEAR, S_RUN} arb_state_t;
endpackage

// File: rtl/id_arb_rr2.sv
// Two-way writer/reader grant logic: round-robin or reader-fixed-priority on ties,
// with the last-grant register that drives the round-robin decision.
module id_arb_rr2 import id_ram_pkg::*; #(
  parameter int PRIORITY_MODE = PRIO_RR
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic wr_req,
  input  logic rd_req,
  output logic wr_gnt,
  output logic rd_gnt
);
  logic last_was_rd_reg;
  logic rd_wins;

  always_comb begin
    rd_wins = 1'b0;
    if (en) begin
      if (wr_req && rd_req)
        rd_wins = (PRIORITY_MODE == PRIO_RD) ? 1'b1 : !last_was_rd_reg;
      else
        rd_wins = rd_req;
    end
  end

  assign rd_gnt = rd_wins;
  assign wr_gnt = en && wr_req && !rd_wins;

  // Starts at "reader last" so the first tie after reset goes to the writer.
  always_ff @(posedge clk) begin
    if (reset)
      last_was_rd_reg <= 1'b1;
    else if (wr_gnt || rd_gnt)
      last_was_rd_reg <= rd_gnt;
  end
endmodule

// File: rtl/id_ram_arbiter.sv
// Sprite-ID RAM access controller: clear sweep after reset, then one arbitrated access per cycle.
// Optional contention counter output enabled by defining ID_ARB_CONTENTION_CNT_EN.
module id_ram_arbiter import id_ram_pkg::*; #(
  parameter int                DATA_W        = ID_DATA_W,
  parameter int                ADDR_W        = ID_ADDR_W,
  parameter int                DEPTH         = ID_DEPTH,
  parameter logic [DATA_W-1:0] CLEAR_VALUE   = '0,
  parameter int                PRIORITY_MODE = PRIO_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef ID_ARB_CONTENTION_CNT_EN
  ,
  output logic [15:0]       contention_cnt
`endif
);
  arb_state_t        state_reg;
  logic [ADDR_W-1:0] clr_cnt_reg;
  logic              rd_valid_reg;
  logic              busy_reg;
  logic              run;

  assign run = (state_reg == S_RUN);

  id_arb_rr2 #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .en     (run),
    .wr_req (wr_req),
    .rd_req (rd_req),
    .wr_gnt (wr_gnt),
    .rd_gnt (rd_gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= S_CLEAR;
      clr_cnt_reg  <= '0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b1;
    end else begin
      rd_valid_reg <= rd_gnt;
      case (state_reg)
        S_CLEAR: begin
          if (clr_cnt_reg == ADDR_W'(DEPTH - 1)) begin
            state_reg   <= S_RUN;
            busy_reg    <= 1'b0;
            clr_cnt_reg <= '0;
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        S_RUN: ;
        default: begin
          state_reg   <= S_CLEAR;
          clr_cnt_reg <= '0;
          busy_reg    <= 1'b1;
        end
      endcase
    end
  end

  // Idle cycles park the RAM port at address 0 with no write.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (!run) begin
      ram_we    = 1'b1;
      ram_addr  = clr_cnt_reg;
      ram_wdata = CLEAR_VALUE;
    end else if (wr_gnt) begin
      ram_we    = 1'b1;
      ram_addr  = wr_addr;
      ram_wdata = wr_data;
    end else if (rd_gnt) begin
      ram_addr  = rd_addr;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = ram_rdata;
  assign busy     = busy_reg;

`ifdef ID_ARB_CONTENTION_CNT_EN
  logic [15:0] contention_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset)
      contention_cnt_reg <= '0;
    else if (run && wr_req && rd_req && contention_cnt_reg != 16'hFFFF)
      contention_cnt_reg <= contention_cnt_reg + 16'd1;
  end

  assign contention_cnt = contention_cnt_reg;
`endif
endmodule
